// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-path constants and the default queue entry type
package fetch_pkg;
  localparam int FETCH_XLEN = 32;
  localparam int FETCH_IW = 32;
  localparam int PC_STEP = 4;
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_IW-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with flush taking priority over push/pop
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        din,
  output entry_t        head,
  output logic [CW-1:0] count
);
  entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  assign head = (count != '0) ? mem[rd_ptr] : '0;
  // pointers wrap naturally at DEPTH; an empty queue presents an all-zero head
  always_ff @(posedge clk) begin
    if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC generator with credit-checked issue feeding a prefetch queue
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN = FETCH_XLEN,
  parameter int IW = FETCH_IW,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            ENABLE,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic [IW-1:0]   IMEM_DATA,
  input  logic            BRANCH_VALID,
  input  logic [XLEN-1:0] BRANCH_TARGET,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [IW-1:0]   OUT_INSTR,
  output logic [XLEN-1:0] OUT_PC,
  output logic [CW-1:0]   COUNT
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic inflight;
  logic kill;
  logic [CW-1:0] count;
  entry_t head;
  entry_t din;
  assign din = {req_pc, IMEM_DATA};
  assign IMEM_REQ = RESET & ENABLE & !BRANCH_VALID & ((count + CW'(inflight)) < CW'(DEPTH));
  assign IMEM_ADDR = fetch_pc;
  assign OUT_VALID = ENABLE & (count != '0);
  assign OUT_INSTR = head.instr;
  assign OUT_PC = head.pc;
  assign COUNT = count;
  fetch_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk(CLOCK),
    .push(inflight & !kill),
    .pop(OUT_VALID & OUT_READY),
    .flush(!RESET | BRANCH_VALID),
    .din(din),
    .head(head),
    .count(count)
  );
  // redirect outranks issue; the in-flight slot is dropped by marking it killed
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      fetch_pc <= RESET_PC;
      req_pc <= '0;
      inflight <= 1'b0;
      kill <= 1'b0;
    end else if (BRANCH_VALID) begin
      fetch_pc <= BRANCH_TARGET & ~XLEN'(3);
      kill <= inflight;
      inflight <= 1'b0;
    end else begin
      inflight <= IMEM_REQ;
      kill <= 1'b0;
      if (IMEM_REQ) begin
        fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        req_pc <= fetch_pc;
      end
    end
  end
endmodule
